// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - load/store unit state and store width encodings
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_WAIT = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

    typedef enum logic [2:0] {
        SF_SB = 3'b000,
        SF_SH = 3'b001,
        SF_SW = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/regfilemux.sv
// rtl/regfilemux.sv - shared write-back mux select encoding
package regfilemux;

    typedef enum logic [3:0] {
        alu_out  = 4'b0000,
        br_en    = 4'b0001,
        u_imm    = 4'b0010,
        lw       = 4'b0011,
        pc_plus4 = 4'b0100,
        lb       = 4'b0101,
        lbu      = 4'b0110,
        lh       = 4'b0111,
        lhu      = 4'b1000
    } regfilemux_sel_t;

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data-cache request/response port
interface mem_lsu_if;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        input  dmem_resp, dmem_rdata
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        output dmem_resp, dmem_rdata
    );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and extends the loaded lane from a cache word
module load_align
    import regfilemux::*;
(
    input  logic [31:0]     rdata,
    input  logic [1:0]      byte_off,
    input  regfilemux_sel_t rf_sel,
    output logic [31:0]     result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (byte_off)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (rf_sel)
            lb:      result = {{24{lane_b[7]}}, lane_b};
            lbu:     result = {24'd0, lane_b};
            lh:      result = {{16{lane_h[15]}}, lane_h};
            lhu:     result = {16'd0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: one cache access per instruction,
// pipeline held with stall until the cache answers or the timeout expires.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    input  logic                       is_load,
    input  logic                       is_store,
    input  logic [2:0]                 funct3,
    input  regfilemux::regfilemux_sel_t rf_sel,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata_in,
    mem_lsu_if.master                  dmem,
    output logic                       stall,
    output logic                       wb_valid,
    output logic [31:0]                load_data,
    output logic                       misalign,
    output logic                       bus_err
);

    lsu_state_t                  state_q, state_d;
    logic [31:0]                 addr_q, wdata_q, cnt_q, fmt_q, fmt_d;
    logic [3:0]                  mbe_q, mbe_d;
    logic [31:0]                 wdata_d;
    regfilemux::regfilemux_sel_t sel_q;
    logic                        store_q;
    logic                        req, is_byte, is_half, mis, accept;

    load_align u_align (
        .rdata    (dmem.dmem_rdata),
        .byte_off (addr_q[1:0]),
        .rf_sel   (sel_q),
        .result   (fmt_d)
    );

    // Access width comes from rf_sel for loads and funct3 for stores.
    always_comb begin
        req = rst_n & mem_valid & (is_load | is_store);
        if (is_load) begin
            is_byte = (rf_sel == regfilemux::lb) || (rf_sel == regfilemux::lbu);
            is_half = (rf_sel == regfilemux::lh) || (rf_sel == regfilemux::lhu);
        end else begin
            is_byte = (funct3 == SF_SB);
            is_half = (funct3 == SF_SH);
        end
        mis = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));

        mbe_d   = 4'b1111;
        wdata_d = wdata_in;
        if (is_load) begin
            wdata_d = '0;
        end else if (is_byte) begin
            mbe_d   = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata_in[7:0]}};
        end else if (is_half) begin
            mbe_d   = 4'b0011 << addr[1:0];
            wdata_d = {2{wdata_in[15:0]}};
        end
    end

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        stall             = 1'b0;
        misalign          = 1'b0;
        bus_err           = 1'b0;
        wb_valid          = 1'b0;
        load_data         = '0;
        dmem.dmem_read    = 1'b0;
        dmem.dmem_write   = 1'b0;
        dmem.dmem_address = '0;
        dmem.dmem_wdata   = '0;
        dmem.dmem_mbe     = '0;
        case (state_q)
            LSU_IDLE: begin
                if (req) begin
                    if (mis) begin
                        misalign = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                stall             = 1'b1;
                dmem.dmem_read    = !store_q;
                dmem.dmem_write   = store_q;
                dmem.dmem_address = {addr_q[31:2], 2'b00};
                dmem.dmem_wdata   = wdata_q;
                dmem.dmem_mbe     = mbe_q;
                if (dmem.dmem_resp) begin
                    state_d = LSU_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT)) begin
                    bus_err = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            LSU_DONE: begin
                wb_valid  = !store_q;
                load_data = store_q ? '0 : fmt_q;
                state_d   = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mbe_q   <= '0;
            sel_q   <= regfilemux::alu_out;
            store_q <= 1'b0;
            cnt_q   <= '0;
            fmt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata_d;
                mbe_q   <= mbe_d;
                sel_q   <= rf_sel;
                store_q <= is_store;
                cnt_q   <= '0;
            end else if (state_q == LSU_WAIT) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if ((state_q == LSU_WAIT) && dmem.dmem_resp) begin
                fmt_q <= fmt_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed bench for mem_lsu with a per-cycle expectation model
module tb_mem_lsu;
    import mem_lsu_pkg::*;
    import regfilemux::*;

    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_valid, is_load, is_store;
    logic [2:0]      funct3;
    regfilemux_sel_t rf_sel;
    logic [31:0]     addr, wdata_in;
    logic            stall, wb_valid, misalign, bus_err;
    logic [31:0]     load_data;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (funct3),
        .rf_sel    (rf_sel),
        .addr      (addr),
        .wdata_in  (wdata_in),
        .dmem      (bus),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .load_data (load_data),
        .misalign  (misalign),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, rd, wr, wbv, mis, berr;
        logic [31:0] adr, wd, ld;
        logic [3:0]  mbe;
        bit          wd_care;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0, n_bad = 0;
    int          stall_cnt, wb_cnt, rd_cnt, wr_cnt, mis_cnt, berr_cnt;
    logic [31:0] last_ld, last_adr, last_wd;
    logic [3:0]  last_mbe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.stall = 0; e.rd = 0; e.wr = 0; e.wbv = 0; e.mis = 0; e.berr = 0;
        e.adr = 0; e.wd = 0; e.ld = 0; e.mbe = 0; e.wd_care = 1;
        return e;
    endfunction

    function automatic int size_of(input bit ld, input logic [2:0] f3, input regfilemux_sel_t sel);
        if (ld) return (sel == lb || sel == lbu) ? 1 : (sel == lh || sel == lhu) ? 2 : 4;
        return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    endfunction

    function automatic logic [31:0] fmt(input regfilemux_sel_t sel, input logic [31:0] rd, input int a);
        logic [31:0] v;
        v = rd;
        if (sel == lb || sel == lbu) begin
            v = (rd >> (8 * a)) & 32'hFF;
            if (sel == lb && v >= 32'h80) v = v - 32'h100;
        end else if (sel == lh || sel == lhu) begin
            v = (rd >> (16 * (a / 2))) & 32'hFFFF;
            if (sel == lh && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("dmem_read", 32'(bus.dmem_read), 32'(e.rd));
            chk("dmem_write", 32'(bus.dmem_write), 32'(e.wr));
            chk("dmem_address", bus.dmem_address, e.adr);
            chk("dmem_mbe", 32'(bus.dmem_mbe), 32'(e.mbe));
            if (e.wd_care) chk("dmem_wdata", bus.dmem_wdata, e.wd);
            chk("wb_valid", 32'(wb_valid), 32'(e.wbv));
            chk("load_data", load_data, e.ld);
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("bus_err", 32'(bus_err), 32'(e.berr));
        end
        if (stall) stall_cnt++;
        if (wb_valid) begin wb_cnt++; last_ld = load_data; end
        if (bus.dmem_read) begin rd_cnt++; last_adr = bus.dmem_address; end
        if (bus.dmem_write) begin
            wr_cnt++; last_adr = bus.dmem_address; last_wd = bus.dmem_wdata; last_mbe = bus.dmem_mbe;
        end
        if (misalign) mis_cnt++;
        if (bus_err) berr_cnt++;
    end

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_cnt = 0; wb_cnt = 0; rd_cnt = 0; wr_cnt = 0; mis_cnt = 0; berr_cnt = 0;
        last_ld = 'x; last_adr = 'x; last_wd = 'x; last_mbe = 'x;
    endtask

    // resp_at: index of the WAIT cycle carrying dmem_resp; negative means never.
    task automatic txn(input bit ld, input logic [2:0] f3, input regfilemux_sel_t sel,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int resp_at);
        exp_t        e;
        int          sz;
        bit          mis, got;
        logic [31:0] wadr, exp_wd;
        logic [3:0]  exp_mbe;
        sz      = size_of(ld, f3, sel);
        mis     = (a % sz) != 0;
        wadr    = a & ~32'h3;
        exp_mbe = 4'((32'((1 << sz) - 1)) << (a % 4));
        exp_wd  = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                  (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        if (ld) exp_mbe = 4'hF;
        clr();
        mem_valid = 1; is_load = ld; is_store = !ld; funct3 = f3; rf_sel = sel;
        addr = a; wdata_in = wd; bus.dmem_resp = 0; bus.dmem_rdata = $urandom;
        e = zero_exp(); e.mis = mis; e.stall = !mis;
        step(e);
        mem_valid = 0;
        if (!mis) begin
            addr = $urandom; wdata_in = $urandom;
            got = 0;
            for (int k = 0; k <= TO; k++) begin
                bit r;
                r = (k == resp_at);
                bus.dmem_resp  = r;
                bus.dmem_rdata = r ? rd : $urandom;
                e = zero_exp();
                e.stall = 1; e.rd = ld; e.wr = !ld; e.adr = wadr; e.mbe = exp_mbe;
                e.wd = exp_wd; e.wd_care = !ld; e.berr = (k == TO) && !r;
                step(e);
                if (r) begin got = 1; break; end
                if (k == TO) break;
            end
            bus.dmem_resp = 0; bus.dmem_rdata = $urandom;
            if (got) begin
                // the held instruction is still presented in DONE and must not be re-accepted
                mem_valid = 1; addr = a; wdata_in = wd;
                e = zero_exp(); e.wbv = ld; e.ld = ld ? fmt(sel, rd, int'(a % 4)) : 32'h0;
                step(e);
                mem_valid = 0;
            end
        end
        step(zero_exp());
    endtask

    initial begin
        exp_t e;
        rst_n = 0; mem_valid = 0; is_load = 0; is_store = 0; funct3 = 0; rf_sel = alu_out;
        addr = 0; wdata_in = 0; bus.dmem_resp = 0; bus.dmem_rdata = 0;
        clr();
        @(posedge clk); #1;
        step(zero_exp());
        bus.dmem_resp = 1; bus.dmem_rdata = 32'h5555AAAA;
        step(zero_exp());
        bus.dmem_resp = 0;
        step(zero_exp());
        rst_n = 1;
        step(zero_exp());

        txn(1, 3'b010, lw, 32'h100, 0, 32'hDEADBEEF, 2);
        chk("lw stall cycles", stall_cnt, 4);
        chk("lw wb pulses", wb_cnt, 1);
        chk("lw data", last_ld, 32'hDEADBEEF);
        chk("lw address", last_adr, 32'h100);

        txn(1, 3'b000, lb, 32'h103, 0, 32'h80FF1234, 0);
        chk("lb data", last_ld, 32'hFFFFFF80);
        chk("lb min latency stall", stall_cnt, 2);
        txn(1, 3'b100, lbu, 32'h103, 0, 32'h80FF1234, 0);
        chk("lbu data", last_ld, 32'h00000080);
        txn(1, 3'b001, lh, 32'h102, 0, 32'h80FF1234, 1);
        chk("lh data", last_ld, 32'hFFFF80FF);
        txn(1, 3'b101, lhu, 32'h100, 0, 32'h80FF1234, 0);
        chk("lhu data", last_ld, 32'h00001234);

        txn(0, 3'b001, alu_out, 32'h202, 32'h0000ABCD, 0, 1);
        chk("sh mbe", 32'(last_mbe), 32'b1100);
        chk("sh wdata", last_wd, 32'hABCDABCD);
        chk("sh address", last_adr, 32'h200);
        chk("sh no wb", wb_cnt, 0);
        txn(0, 3'b000, alu_out, 32'h201, 32'h123456EF, 0, 0);
        chk("sb mbe", 32'(last_mbe), 32'b0010);
        chk("sb wdata", last_wd, 32'hEFEFEFEF);
        txn(0, 3'b010, alu_out, 32'h204, 32'hCAFEF00D, 0, 3);
        chk("sw mbe", 32'(last_mbe), 32'b1111);

        txn(1, 3'b010, lw, 32'h101, 0, 0, 0);
        chk("misalign pulses", mis_cnt, 1);
        chk("misalign no read", rd_cnt, 0);
        chk("misalign no stall", stall_cnt, 0);
        txn(0, 3'b001, alu_out, 32'h203, 32'h1, 0, 0);
        txn(1, 3'b001, lh, 32'h101, 0, 0, 0);
        txn(1, 3'b010, lw, 32'h10E, 0, 0, 0);
        txn(1, 3'b101, lhu, 32'h102, 0, 32'hBEEF0001, 0);
        chk("lhu upper data", last_ld, 32'h0000BEEF);

        bus.dmem_resp = 1; bus.dmem_rdata = 32'h12345678;
        step(zero_exp());
        bus.dmem_resp = 0;

        clr();
        mem_valid = 1; is_load = 1; is_store = 0; rf_sel = lw; addr = 32'h400;
        e = zero_exp(); e.stall = 1;
        step(e);
        mem_valid = 0;
        e = zero_exp(); e.stall = 1; e.rd = 1; e.adr = 32'h400; e.mbe = 4'hF; e.wd_care = 0;
        step(e);
        rst_n = 0;
        step(zero_exp());
        step(zero_exp());
        rst_n = 1; bus.dmem_resp = 1; bus.dmem_rdata = 32'hFEEDFACE;
        step(zero_exp());
        bus.dmem_resp = 0;
        step(zero_exp());
        chk("reset abort no wb", wb_cnt, 0);

        txn(1, 3'b010, lw, 32'h300, 0, 0, -1);
        chk("timeout bus_err pulses", berr_cnt, 1);
        chk("timeout stall cycles", stall_cnt, TO + 2);
        chk("timeout no wb", wb_cnt, 0);
        bus.dmem_resp = 1; bus.dmem_rdata = 32'h0BADF00D;
        step(zero_exp());
        bus.dmem_resp = 0;

        txn(1, 3'b010, lw, 32'h304, 0, 32'hA5A5C3C3, TO - 1);
        chk("late resp data", last_ld, 32'hA5A5C3C3);
        chk("late resp no bus_err", berr_cnt, 0);

        step(zero_exp());
        chk("expectations drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
